// File: rtl/flux_rr_scheduler_if.sv
// Handshake bundle between a multi-flux actor and its round-robin tag scheduler.
// The actor is the master: it raises per-flux ready bits and fire, and consumes the grant.
interface flux_rr_scheduler_if #(
  parameter int FLUX    = 2,
  parameter int QUANTUM = 4
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_WIDTH = $clog2(QUANTUM + 1);

  logic [FLUX-1:0]      req;
  logic                 fire;
  logic                 grant_valid;
  logic [TAG_WIDTH-1:0] grant_tag;
  logic [FLUX-1:0]      grant_vec;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic                 err;

  modport master (
    output req, fire,
    input  grant_valid, grant_tag, grant_vec, burst_cnt, err
  );

  modport slave (
    input  req, fire,
    output grant_valid, grant_tag, grant_vec, burst_cnt, err
  );
endinterface

// File: rtl/flux_rr_scheduler.sv
// Round-robin grant-tag scheduler with a per-flux burst quantum.
// The grant is combinational from the registered owner/burst state and the current req.
module flux_rr_scheduler #(
  parameter int FLUX    = 2,
  parameter int QUANTUM = 4
) (
  input logic                 clk,
  input logic                 rst,
  flux_rr_scheduler_if.slave  bus
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_WIDTH = $clog2(QUANTUM + 1);
  localparam logic [CNT_WIDTH-1:0] QMAX = CNT_WIDTH'(QUANTUM);

  logic [TAG_WIDTH-1:0] owner;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic                 err;
  logic                 sel_valid;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic                 sticky;
  int                   idx;

  // The owner keeps the grant mid-tenure; otherwise scan owner+1 onward, owner itself last.
  always_comb begin
    sel_valid = 1'b0;
    sel_tag   = '0;
    idx       = 0;
    sticky    = (burst_cnt != '0) && (burst_cnt < QMAX) && bus.req[owner];
    if (sticky) begin
      sel_valid = 1'b1;
      sel_tag   = owner;
    end else begin
      for (int k = 1; k <= FLUX; k++) begin
        idx = int'(owner) + k;
        if (idx >= FLUX) idx = idx - FLUX;
        if (!sel_valid && bus.req[TAG_WIDTH'(idx)]) begin
          sel_valid = 1'b1;
          sel_tag   = TAG_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    bus.grant_valid = 1'b0;
    bus.grant_tag   = '0;
    bus.grant_vec   = '0;
    if (!rst && sel_valid) begin
      bus.grant_valid        = 1'b1;
      bus.grant_tag          = sel_tag;
      bus.grant_vec[sel_tag] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= TAG_WIDTH'(FLUX - 1);
      burst_cnt <= '0;
      err       <= 1'b0;
    end else if (bus.fire) begin
      if (!sel_valid) begin
        err <= 1'b1;
      end else if (sel_tag != owner) begin
        owner     <= sel_tag;
        burst_cnt <= CNT_WIDTH'(1);
      end else if (burst_cnt < QMAX) begin
        burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      end else begin
        // Sole requester re-wins after its quantum: start a new tenure with no idle gap.
        burst_cnt <= CNT_WIDTH'(1);
      end
    end
  end

  assign bus.burst_cnt = burst_cnt;
  assign bus.err       = err;
endmodule
